// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the memory port arbiter, its three requesters and the
// byte-wide memory controller.
interface ram_port_arbiter_if #(
  parameter int AW = 23
);
  // Requesters hold *_req (with we/addr/din stable) until the one-cycle *_ack.
  // The controller takes a one-cycle mem_we/mem_rd strobe, drops mem_ready
  // while working and raises it again on completion.
  logic          ioctl_download;
  logic          ioctl_wr;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_data;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din;
  logic [7:0]    cpu_dout;
  logic          cpu_ack;

  logic          aux_req;
  logic          aux_we;
  logic [AW-1:0] aux_addr;
  logic [7:0]    aux_din;
  logic [7:0]    aux_dout;
  logic          aux_ack;

  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic [7:0]    mem_dout;
  logic          mem_we;
  logic          mem_rd;
  logic          mem_ready;

  logic          load_overflow;
  logic          mem_timeout;
  logic          busy;
  logic [2:0]    dbg_state;

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_data,
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    input  aux_req, aux_we, aux_addr, aux_din,
    input  mem_dout, mem_ready,
    output cpu_dout, cpu_ack, aux_dout, aux_ack,
    output mem_addr, mem_din, mem_we, mem_rd,
    output load_overflow, mem_timeout, busy, dbg_state
  );

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_data,
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    output aux_req, aux_we, aux_addr, aux_din,
    output mem_dout, mem_ready,
    input  cpu_dout, cpu_ack, aux_dout, aux_ack,
    input  mem_addr, mem_din, mem_we, mem_rd,
    input  load_overflow, mem_timeout, busy, dbg_state
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one byte-wide memory controller port between the ioctl loader, the
// CPU and an auxiliary DMA requester, sequencing each access on mem_ready.
module ram_port_arbiter #(
  parameter int AW         = 23,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input logic             clk_sys,
  input logic             res_n,
  ram_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT_LO = 3'd2,
    S_WAIT_HI = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  typedef enum logic [1:0] {SRC_LOAD, SRC_CPU, SRC_AUX} src_t;

  state_t        state;
  src_t          src;
  logic          acc_we;
  logic          buf_full;
  logic [AW-1:0] buf_addr;
  logic [7:0]    buf_data;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] to_cnt;
  logic          dl_q;

  logic          gnt_valid;
  src_t          gnt_src;
  logic          gnt_we;
  logic [AW-1:0] gnt_addr;
  logic [7:0]    gnt_data;
  logic          consume;
  logic          finish;
  logic          timed_out;
  logic          go_hi;

  assign bus.busy      = (state != S_IDLE);
  assign bus.dbg_state = state;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_src   = SRC_LOAD;
    gnt_we    = 1'b1;
    gnt_addr  = buf_addr;
    gnt_data  = buf_data;
    if (state == S_IDLE && bus.mem_ready) begin
      if (buf_full) begin
        gnt_valid = 1'b1;
      end else if (!bus.ioctl_download) begin
        if (bus.aux_req && starve_cnt == SW'(STARVE_MAX)) begin
          gnt_valid = 1'b1;
          gnt_src   = SRC_AUX;
        end else if (bus.cpu_req) begin
          gnt_valid = 1'b1;
          gnt_src   = SRC_CPU;
        end else if (bus.aux_req) begin
          gnt_valid = 1'b1;
          gnt_src   = SRC_AUX;
        end
      end
    end
    if (gnt_src == SRC_CPU) begin
      gnt_we   = bus.cpu_we;
      gnt_addr = bus.cpu_addr;
      gnt_data = bus.cpu_din;
    end else if (gnt_src == SRC_AUX) begin
      gnt_we   = bus.aux_we;
      gnt_addr = bus.aux_addr;
      gnt_data = bus.aux_din;
    end
    // The loader entry is freed once it moves into the access registers, so
    // one more byte can queue behind a write that is still in flight.
    consume = gnt_valid && (gnt_src == SRC_LOAD);
  end

  always_comb begin
    finish    = 1'b0;
    timed_out = 1'b0;
    go_hi     = 1'b0;
    if (state == S_WAIT_LO) begin
      // A controller that never drops ready is taken as already complete.
      if (bus.mem_ready && to_cnt == TW'(1)) begin
        finish = 1'b1;
      end else if (to_cnt == TW'(TIMEOUT - 1)) begin
        finish    = 1'b1;
        timed_out = 1'b1;
      end else if (!bus.mem_ready) begin
        go_hi = 1'b1;
      end
    end else if (state == S_WAIT_HI) begin
      if (bus.mem_ready) begin
        finish = 1'b1;
      end else if (to_cnt == TW'(TIMEOUT - 1)) begin
        finish    = 1'b1;
        timed_out = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      state             <= S_IDLE;
      src               <= SRC_LOAD;
      acc_we            <= 1'b0;
      buf_full          <= 1'b0;
      buf_addr          <= '0;
      buf_data          <= '0;
      starve_cnt        <= '0;
      to_cnt            <= '0;
      dl_q              <= 1'b0;
      bus.cpu_dout      <= '0;
      bus.cpu_ack       <= 1'b0;
      bus.aux_dout      <= '0;
      bus.aux_ack       <= 1'b0;
      bus.mem_addr      <= '0;
      bus.mem_din       <= '0;
      bus.mem_we        <= 1'b0;
      bus.mem_rd        <= 1'b0;
      bus.load_overflow <= 1'b0;
      bus.mem_timeout   <= 1'b0;
    end else begin
      dl_q        <= bus.ioctl_download;
      bus.mem_we  <= 1'b0;
      bus.mem_rd  <= 1'b0;
      bus.cpu_ack <= 1'b0;
      bus.aux_ack <= 1'b0;

      if (bus.ioctl_download && !dl_q) begin
        bus.load_overflow <= 1'b0;
        bus.mem_timeout   <= 1'b0;
      end

      if (bus.ioctl_wr) begin
        if (!buf_full || consume) begin
          buf_full <= 1'b1;
          buf_addr <= bus.ioctl_addr;
          buf_data <= bus.ioctl_data;
        end else begin
          bus.load_overflow <= 1'b1;
        end
      end else if (consume) begin
        buf_full <= 1'b0;
      end

      if (!bus.aux_req || (gnt_valid && gnt_src == SRC_AUX)) begin
        starve_cnt <= '0;
      end else if (gnt_valid && gnt_src == SRC_CPU && starve_cnt != SW'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (gnt_valid) begin
            src          <= gnt_src;
            acc_we       <= gnt_we;
            bus.mem_addr <= gnt_addr;
            bus.mem_din  <= gnt_data;
            bus.mem_we   <= gnt_we;
            bus.mem_rd   <= !gnt_we;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          to_cnt <= '0;
          state  <= S_WAIT_LO;
        end
        S_WAIT_LO, S_WAIT_HI: begin
          if (finish) begin
            state <= S_DONE;
            if (timed_out) bus.mem_timeout <= 1'b1;
            // Ack and read data are registered together so both are seen in DONE.
            if (src == SRC_CPU) begin
              bus.cpu_ack <= 1'b1;
              if (!acc_we) bus.cpu_dout <= bus.mem_dout;
            end else if (src == SRC_AUX) begin
              bus.aux_ack <= 1'b1;
              if (!acc_we) bus.aux_dout <= bus.mem_dout;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
            if (go_hi) state <= S_WAIT_HI;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
